// File: rtl/jelly2_video_frame_source_pkg.sv
// Shared definitions for the video frame source.
// Only the controller state encoding lives here.
package jelly2_video_frame_source_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      GAP
   } state_t;

endpackage

// File: rtl/jelly2_video_frame_source_pattern.sv
// Combinational test pattern: each component is
// (x + y + frame + component index) truncated to DATA_WIDTH.
module jelly2_video_frame_source_pattern #(
   parameter int COMPONENTS      = 3,
   parameter int DATA_WIDTH      = 8,
   parameter int IMG_X_WIDTH     = 10,
   parameter int IMG_Y_WIDTH     = 9,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic [IMG_X_WIDTH-1:0]           x,
   input  logic [IMG_Y_WIDTH-1:0]           y,
   input  logic [FRAME_CNT_WIDTH-1:0]       frame_count,
   output logic [COMPONENTS*DATA_WIDTH-1:0] data
);

   for (genvar c = 0; c < COMPONENTS; c++) begin : g_comp
      assign data[c*DATA_WIDTH +: DATA_WIDTH] =
         DATA_WIDTH'(x)
         + DATA_WIDTH'(y)
         + DATA_WIDTH'(frame_count)
         + DATA_WIDTH'(c);
   end

endmodule

// File: rtl/jelly2_video_frame_source.sv
// AXI4-Stream video frame generator with per-frame parameter latch,
// inter-frame gap and registered outputs.
module jelly2_video_frame_source
   import jelly2_video_frame_source_pkg::*;
#(
   parameter int TUSER_WIDTH     = 1,
   parameter int COMPONENTS      = 3,
   parameter int DATA_WIDTH      = 8,
   parameter int IMG_X_WIDTH     = 10,
   parameter int IMG_Y_WIDTH     = 9,
   parameter int GAP_WIDTH       = 8,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                             aresetn,
   input  logic                             aclk,
   input  logic                             aclken,
   input  logic                             ctl_enable,
   input  logic [IMG_X_WIDTH-1:0]           param_img_width,
   input  logic [IMG_Y_WIDTH-1:0]           param_img_height,
   input  logic [GAP_WIDTH-1:0]             param_frame_gap,
   output logic                             ctl_busy,
   output logic [FRAME_CNT_WIDTH-1:0]       frame_count,
   output logic [TUSER_WIDTH-1:0]           m_axi4s_tuser,
   output logic                             m_axi4s_tlast,
   output logic [COMPONENTS*DATA_WIDTH-1:0] m_axi4s_tdata,
   output logic                             m_axi4s_tvalid,
   input  logic                             m_axi4s_tready
);

   state_t                           state, nxt_state;
   logic [IMG_X_WIDTH-1:0]           x, nxt_x;
   logic [IMG_Y_WIDTH-1:0]           y, nxt_y;
   logic [FRAME_CNT_WIDTH-1:0]       nxt_fc;
   logic [IMG_X_WIDTH-1:0]           width, nxt_width;
   logic [IMG_Y_WIDTH-1:0]           height, nxt_height;
   logic [GAP_WIDTH-1:0]             gap, nxt_gap;
   logic [GAP_WIDTH-1:0]             gap_cnt, nxt_gap_cnt;
   logic                             start_ok;
   logic                             load;
   logic                             nxt_valid;
   logic [COMPONENTS*DATA_WIDTH-1:0] pat;

   assign start_ok = ctl_enable
                   && (param_img_width != '0)
                   && (param_img_height != '0);

   always_comb begin
      nxt_state   = state;
      nxt_x       = x;
      nxt_y       = y;
      nxt_fc      = frame_count;
      nxt_width   = width;
      nxt_height  = height;
      nxt_gap     = gap;
      nxt_gap_cnt = gap_cnt;
      load        = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_ok) load = 1'b1;
         end
         ACTIVE: begin
            // tvalid is always high here, so tready alone means transfer
            if (m_axi4s_tready) begin
               if (x == width - IMG_X_WIDTH'(1)) begin
                  nxt_x = '0;
                  if (y == height - IMG_Y_WIDTH'(1)) begin
                     nxt_y  = '0;
                     nxt_fc = frame_count + FRAME_CNT_WIDTH'(1);
                     if (gap != '0) begin
                        nxt_state   = GAP;
                        nxt_gap_cnt = gap;
                     end else if (start_ok) begin
                        load = 1'b1;
                     end else begin
                        nxt_state = IDLE;
                     end
                  end else begin
                     nxt_y = y + IMG_Y_WIDTH'(1);
                  end
               end else begin
                  nxt_x = x + IMG_X_WIDTH'(1);
               end
            end
         end
         GAP: begin
            if (gap_cnt <= GAP_WIDTH'(1)) begin
               if (start_ok) load = 1'b1;
               else          nxt_state = IDLE;
            end else begin
               nxt_gap_cnt = gap_cnt - GAP_WIDTH'(1);
            end
         end
         default: nxt_state = IDLE;
      endcase
      if (load) begin
         nxt_state  = ACTIVE;
         nxt_x      = '0;
         nxt_y      = '0;
         nxt_width  = param_img_width;
         nxt_height = param_img_height;
         nxt_gap    = param_frame_gap;
      end
   end

   assign nxt_valid = (nxt_state == ACTIVE);

   jelly2_video_frame_source_pattern #(
      .COMPONENTS      (COMPONENTS),
      .DATA_WIDTH      (DATA_WIDTH),
      .IMG_X_WIDTH     (IMG_X_WIDTH),
      .IMG_Y_WIDTH     (IMG_Y_WIDTH),
      .FRAME_CNT_WIDTH (FRAME_CNT_WIDTH)
   ) u_pattern (
      .x           (nxt_x),
      .y           (nxt_y),
      .frame_count (nxt_fc),
      .data        (pat)
   );

   // Outputs are computed from next-state values so they are registered
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state          <= IDLE;
         x              <= '0;
         y              <= '0;
         frame_count    <= '0;
         width          <= '0;
         height         <= '0;
         gap            <= '0;
         gap_cnt        <= '0;
         ctl_busy       <= 1'b0;
         m_axi4s_tvalid <= 1'b0;
         m_axi4s_tuser  <= '0;
         m_axi4s_tlast  <= 1'b0;
         m_axi4s_tdata  <= '0;
      end else if (aclken) begin
         state          <= nxt_state;
         x              <= nxt_x;
         y              <= nxt_y;
         frame_count    <= nxt_fc;
         width          <= nxt_width;
         height         <= nxt_height;
         gap            <= nxt_gap;
         gap_cnt        <= nxt_gap_cnt;
         ctl_busy       <= (nxt_state != IDLE);
         m_axi4s_tvalid <= nxt_valid;
         m_axi4s_tuser  <= TUSER_WIDTH'(nxt_valid
                           && (nxt_x == '0) && (nxt_y == '0));
         m_axi4s_tlast  <= nxt_valid
                           && (nxt_x == nxt_width - IMG_X_WIDTH'(1));
         m_axi4s_tdata  <= nxt_valid ? pat : '0;
      end
   end

endmodule

// File: tb/tb_jelly2_video_frame_source.sv
// Directed bench for the video frame source: a cycle table plus
// hand sequences for backpressure, gap 0, reset and width edge cases.
module tb_jelly2_video_frame_source;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        aclken;
   logic        ctl_enable;
   logic [9:0]  param_img_width;
   logic [8:0]  param_img_height;
   logic [7:0]  param_frame_gap;
   logic        ctl_busy;
   logic [15:0] frame_count;
   logic [0:0]  m_axi4s_tuser;
   logic        m_axi4s_tlast;
   logic [23:0] m_axi4s_tdata;
   logic        m_axi4s_tvalid;
   logic        m_axi4s_tready;

   int checks = 0;
   int errors = 0;

   jelly2_video_frame_source dut (
      .aresetn          (aresetn),
      .aclk             (aclk),
      .aclken           (aclken),
      .ctl_enable       (ctl_enable),
      .param_img_width  (param_img_width),
      .param_img_height (param_img_height),
      .param_frame_gap  (param_frame_gap),
      .ctl_busy         (ctl_busy),
      .frame_count      (frame_count),
      .m_axi4s_tuser    (m_axi4s_tuser),
      .m_axi4s_tlast    (m_axi4s_tlast),
      .m_axi4s_tdata    (m_axi4s_tdata),
      .m_axi4s_tvalid   (m_axi4s_tvalid),
      .m_axi4s_tready   (m_axi4s_tready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic        en;
      logic        rdy;
      logic        ce;
      logic        v;
      logic        u;
      logic        l;
      logic [7:0]  c0;
      logic [15:0] fc;
      logic        busy;
   } vec_t;

   vec_t tbl [29];

   function automatic vec_t mkv(input int en, input int rdy,
                                input int ce, input int v,
                                input int u, input int l,
                                input int c0, input int fc,
                                input int busy);
      vec_t r;
      r.en   = 1'(en);
      r.rdy  = 1'(rdy);
      r.ce   = 1'(ce);
      r.v    = 1'(v);
      r.u    = 1'(u);
      r.l    = 1'(l);
      r.c0   = 8'(c0);
      r.fc   = 16'(fc);
      r.busy = 1'(busy);
      return r;
   endfunction

   function automatic logic [23:0] pix(input logic [7:0] c0);
      logic [7:0] a, b;
      a = c0 + 8'd1;
      b = c0 + 8'd2;
      return {b, a, c0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      aresetn        = 1'b0;
      ctl_enable     = 1'b0;
      aclken         = 1'b1;
      m_axi4s_tready = 1'b1;
      repeat (2) step();
      aresetn = 1'b1;
      step();
   endtask

   task automatic chk_beat(input string name, input logic u,
                           input logic l, input logic [7:0] c0);
      chk(name, {m_axi4s_tvalid, m_axi4s_tuser[0], m_axi4s_tlast,
                 m_axi4s_tdata}, {1'b1, u, l, pix(c0)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      int cyc;
      logic [26:0] snap;
      logic snap_v, snap_r;

      // 4x2 frame, gap 3; a 5-cycle clock-enable hold mid-frame 2;
      // enable dropped after beat 2 of frame 2
      tbl[0]  = mkv(1,1,1, 1,1,0,0, 0,1);
      tbl[1]  = mkv(1,1,1, 1,0,0,1, 0,1);
      tbl[2]  = mkv(1,1,1, 1,0,0,2, 0,1);
      tbl[3]  = mkv(1,1,1, 1,0,1,3, 0,1);
      tbl[4]  = mkv(1,1,1, 1,0,0,1, 0,1);
      tbl[5]  = mkv(1,1,1, 1,0,0,2, 0,1);
      tbl[6]  = mkv(1,1,1, 1,0,0,3, 0,1);
      tbl[7]  = mkv(1,1,1, 1,0,1,4, 0,1);
      tbl[8]  = mkv(1,1,1, 0,0,0,0, 1,1);
      tbl[9]  = mkv(1,1,1, 0,0,0,0, 1,1);
      tbl[10] = mkv(1,1,1, 0,0,0,0, 1,1);
      tbl[11] = mkv(1,1,1, 1,1,0,1, 1,1);
      tbl[12] = mkv(1,1,1, 1,0,0,2, 1,1);
      for (int i = 13; i < 18; i++)
         tbl[i] = mkv(1,1,0, 1,0,0,2, 1,1);
      tbl[18] = mkv(1,1,1, 1,0,0,3, 1,1);
      tbl[19] = mkv(0,1,1, 1,0,1,4, 1,1);
      tbl[20] = mkv(0,1,1, 1,0,0,2, 1,1);
      tbl[21] = mkv(0,1,1, 1,0,0,3, 1,1);
      tbl[22] = mkv(0,1,1, 1,0,0,4, 1,1);
      tbl[23] = mkv(0,1,1, 1,0,1,5, 1,1);
      tbl[24] = mkv(0,1,1, 0,0,0,0, 2,1);
      tbl[25] = mkv(0,1,1, 0,0,0,0, 2,1);
      tbl[26] = mkv(0,1,1, 0,0,0,0, 2,1);
      tbl[27] = mkv(0,1,1, 0,0,0,0, 2,0);
      tbl[28] = mkv(0,1,1, 0,0,0,0, 2,0);

      aresetn          = 1'b0;
      aclken           = 1'b1;
      ctl_enable       = 1'b0;
      m_axi4s_tready   = 1'b1;
      param_img_width  = 10'd4;
      param_img_height = 9'd2;
      param_frame_gap  = 8'd3;
      repeat (2) step();
      chk("reset_ctl", {ctl_busy, m_axi4s_tvalid, m_axi4s_tuser,
                        m_axi4s_tlast}, 4'b0);
      chk("reset_data", {frame_count, m_axi4s_tdata}, 40'd0);

      do_reset();
      for (int i = 0; i < 29; i++) begin
         ctl_enable     = tbl[i].en;
         m_axi4s_tready = tbl[i].rdy;
         aclken         = tbl[i].ce;
         step();
         chk($sformatf("vec%0d valid", i), m_axi4s_tvalid, tbl[i].v);
         chk($sformatf("vec%0d busy", i), ctl_busy, tbl[i].busy);
         chk($sformatf("vec%0d fc", i), frame_count, tbl[i].fc);
         if (tbl[i].v) begin
            chk($sformatf("vec%0d user", i), m_axi4s_tuser[0],
                tbl[i].u);
            chk($sformatf("vec%0d last", i), m_axi4s_tlast, tbl[i].l);
            chk($sformatf("vec%0d data", i), m_axi4s_tdata,
                pix(tbl[i].c0));
         end
      end

      // random backpressure
      do_reset();
      ctl_enable = 1'b1;
      beats = 0;
      cyc = 0;
      while (beats < 8 && cyc < 200) begin
         m_axi4s_tready = 1'($urandom_range(0, 1));
         if (m_axi4s_tvalid && m_axi4s_tready) begin
            chk_beat($sformatf("bp beat%0d", beats), beats == 0,
                     (beats % 4) == 3, 8'((beats % 4) + (beats / 4)));
            beats++;
         end
         snap   = {m_axi4s_tvalid, m_axi4s_tuser[0], m_axi4s_tlast,
                   m_axi4s_tdata};
         snap_v = m_axi4s_tvalid;
         snap_r = m_axi4s_tready;
         step();
         cyc++;
         if (snap_v && !snap_r)
            chk($sformatf("bp hold cyc%0d", cyc),
                {m_axi4s_tvalid, m_axi4s_tuser[0], m_axi4s_tlast,
                 m_axi4s_tdata}, snap);
      end
      chk("bp beats", beats, 8);
      chk("bp gap valid", m_axi4s_tvalid, 1'b0);
      chk("bp fc", frame_count, 16'd1);

      // gap 0 back-to-back frames
      m_axi4s_tready   = 1'b1;
      do_reset();
      param_img_width  = 10'd3;
      param_img_height = 9'd1;
      param_frame_gap  = 8'd0;
      ctl_enable       = 1'b1;
      step();
      for (int k = 0; k < 9; k++) begin
         chk_beat($sformatf("g0 beat%0d", k), (k % 3) == 0,
                  (k % 3) == 2, 8'((k % 3) + (k / 3)));
         step();
      end

      // width 1: every beat is end of line
      do_reset();
      param_img_width  = 10'd1;
      param_img_height = 9'd2;
      ctl_enable       = 1'b1;
      step();
      chk_beat("w1 beat0", 1'b1, 1'b1, 8'd0);
      step();
      chk_beat("w1 beat1", 1'b0, 1'b1, 8'd1);
      step();
      chk_beat("w1 beat2", 1'b1, 1'b1, 8'd1);

      // width 0 never starts
      do_reset();
      param_img_width = 10'd0;
      ctl_enable      = 1'b1;
      repeat (3) step();
      chk("w0 idle", {ctl_busy, m_axi4s_tvalid}, 2'b00);

      // asynchronous reset at beat 5 of the second frame
      do_reset();
      param_img_width  = 10'd4;
      param_img_height = 9'd2;
      param_frame_gap  = 8'd3;
      ctl_enable       = 1'b1;
      repeat (17) step();
      chk_beat("rst pre beat", 1'b0, 1'b0, 8'd3);
      chk("rst pre fc", frame_count, 16'd1);
      #2 aresetn = 1'b0;
      #1;
      chk("rst async ctl", {ctl_busy, m_axi4s_tvalid, m_axi4s_tuser,
                            m_axi4s_tlast}, 4'b0);
      chk("rst async data", {frame_count, m_axi4s_tdata}, 40'd0);
      step();
      aresetn = 1'b1;
      step();
      chk_beat("rst sof", 1'b1, 1'b0, 8'd0);
      chk("rst sof fc", frame_count, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jelly2_video_frame_source.md
JELLY2_VIDEO_FRAME_SOURCE -- requirements
Module: jelly2_video_frame_source

Interface
REQ-001 Parameter TUSER_WIDTH, default 1; width of m_axi4s_tuser.
REQ-002 Parameter COMPONENTS, default 3; pixel components per beat.
REQ-003 Parameter DATA_WIDTH, default 8; bits per component.
REQ-004 Parameter IMG_X_WIDTH, default 10; width counter bits.
REQ-005 Parameter IMG_Y_WIDTH, default 9; height counter bits.
REQ-006 Parameter GAP_WIDTH, default 8; inter-frame gap counter bits.
REQ-007 Parameter FRAME_CNT_WIDTH, default 16; frame counter bits.
REQ-008 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-009 Ports SHALL be:
- aresetn  in  1  async active-low reset
- aclk  in  1  clock
- aclken  in  1  clock enable; 0 freezes all state and outputs
- ctl_enable  in  1  generate frames while high
- param_img_width  in  IMG_X_WIDTH  pixels per line
- param_img_height  in  IMG_Y_WIDTH  lines per frame
- param_frame_gap  in  GAP_WIDTH  idle cycles between frames
- ctl_busy  out  1  high while not IDLE
- frame_count  out  FRAME_CNT_WIDTH  completed frames
- m_axi4s_tuser  out  TUSER_WIDTH  bit0 = start of frame, others 0
- m_axi4s_tlast  out  1  end of line
- m_axi4s_tdata  out  COMPONENTS*DATA_WIDTH  pixel, component c at [c*DATA_WIDTH +: DATA_WIDTH]
- m_axi4s_tvalid  out  1  beat valid
- m_axi4s_tready  in  1  sink ready

Function
REQ-010 FSM states SHALL be IDLE, ACTIVE, GAP; all outputs registered.
REQ-011 IDLE -> ACTIVE on a clock with aclken=1, ctl_enable=1, width!=0, height!=0; first tvalid SHALL rise the following cycle.
REQ-012 param_img_width, param_img_height, param_frame_gap SHALL be latched on IDLE->ACTIVE and GAP->ACTIVE; changes mid-frame have no effect.
REQ-013 Width or height 0 SHALL keep the block in IDLE.
REQ-014 A beat transfers when tvalid && tready && aclken; once asserted, tvalid and all payload SHALL hold stable until transfer.
REQ-015 In ACTIVE, tvalid SHALL be 1 continuously; x increments per transfer, wraps to 0 after width-1 with y increment.
REQ-016 tuser[0] SHALL be 1 only at x=0,y=0; tlast SHALL be 1 only at x=width-1.
REQ-017 Component c SHALL equal (x + y + frame_count + c) modulo 2^DATA_WIDTH.
REQ-018 On transfer of x=width-1,y=height-1: frame_count increments (wraps at 2^FRAME_CNT_WIDTH); next state GAP if latched gap!=0, else ACTIVE (if ctl_enable) or IDLE.
REQ-019 Gap 0 with ctl_enable=1 SHALL give back-to-back frames: next SOF valid in the cycle after last-pixel transfer.
REQ-020 GAP SHALL hold tvalid=0 for exactly the latched gap count of enabled cycles, then enter ACTIVE if ctl_enable=1, else IDLE.
REQ-021 ctl_enable falling mid-frame SHALL NOT truncate the frame; current frame and its gap complete, then IDLE.
REQ-022 ctl_busy SHALL be 0 only in IDLE.
REQ-023 Width 1 SHALL assert tuser and tlast together on the single first beat; every beat has tlast=1.

Reset
REQ-024 aresetn low SHALL immediately force IDLE, x=y=0, frame_count=0, tvalid=0, tuser=0, tlast=0, tdata=0, ctl_busy=0.
REQ-025 Reset mid-frame SHALL abandon the frame; after release the next frame starts with SOF at x=0,y=0 and frame_count=0.

Structure
REQ-026 State enum (IDLE/ACTIVE/GAP) SHALL live in shared package jelly2_video_frame_source_pkg; no other constants shared.
REQ-027 One sub-module SHALL be natural: jelly2_video_frame_source_pattern, combinational pattern from x, y, frame_count; the FSM/counters stay in the top.

Verification
REQ-028 Width 4, height 2, gap 3, tready=1, enable held: 8 beats, tuser on beat 0, tlast on beats 3 and 7, comp0 of beat 5 = 2; then 3 cycles tvalid=0; frame_count=1; second SOF comp0 = 1.
REQ-029 Width 4, height 2, random tready (50%): payload stable while tvalid&&!tready; same 8-beat sequence as REQ-028.
REQ-030 Gap 0, width 3, height 1: tvalid never drops between frames; tuser/tlast beat order 1/0,0/0,0/1 repeats.
REQ-031 Deassert ctl_enable after beat 2 of a 4x2 frame: all 8 beats still emitted, then gap, then IDLE with ctl_busy=0.
REQ-032 aresetn pulsed low at beat 5: outputs zero asynchronously; after release with enable, SOF at x=0,y=0, frame_count=0.
REQ-033 aclken=0 for 5 cycles mid-frame with tready=1: no transfers, outputs frozen, sequence resumes unchanged.
